// File: rtl/ecc_pkg.sv
// Shared ECC scheduler definitions: encoder mode codes, default width and the response record.
package ecc_pkg;

  localparam logic [1:0] MOD_8       = 2'b00;
  localparam logic [1:0] MOD_16      = 2'b01;
  localparam logic [1:0] MOD_32      = 2'b10;
  localparam logic [1:0] MOD_ILLEGAL = 2'b11;

  localparam int CODEWORD_W_DEF = 32;
  localparam int ID_W_MAX       = 3;

  typedef struct packed {
    logic [CODEWORD_W_DEF-1:0] data;
    logic [ID_W_MAX-1:0]       id;
    logic                      err;
  } ecc_rsp_t;

  function automatic logic is_illegal_mod(input logic [1:0] m);
    return m == MOD_ILLEGAL;
  endfunction

endpackage

// File: rtl/ecc_rsp_fifo.sv
// Synchronous response FIFO (power-of-two depth) with occupancy count and full/empty flags.
module ecc_rsp_fifo
  import ecc_pkg::*;
#(
  parameter int  WIDTH = CODEWORD_W_DEF + ID_W_MAX + 1,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head reads as zero while empty so the response bus idles at zero.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_enc_sched.sv
// Round-robin scheduler sharing one ECC encoder among NUM_REQ requesters, credit-protected output FIFO.
// Optional issue/stall statistics counters are built when ECC_SCHED_STATS_EN is defined.
module ecc_enc_sched
  import ecc_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  CODEWORD_W  = CODEWORD_W_DEF,
  parameter int  ENC_LATENCY = 1,
  parameter int  FIFO_DEPTH  = 4,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*CODEWORD_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_mod,
  output logic [CODEWORD_W-1:0]         enc_data_in,
  output logic [1:0]                    enc_mod,
  input  logic [CODEWORD_W-1:0]         enc_data_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CODEWORD_W-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_err
`ifdef ECC_SCHED_STATS_EN
  ,
  output logic [15:0]                   stat_issue_cnt,
  output logic [15:0]                   stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 3;
  localparam int FW    = CODEWORD_W + ID_W + 1;

  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;
  logic                  grant_found;
  logic                  has_credit;
  logic                  issue;
  logic [CODEWORD_W-1:0] grant_data;
  logic [1:0]            grant_mod;
  logic [OCC_W-1:0]      inflight_cnt;
  logic [OCC_W-1:0]      occupancy;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_rdata;
  logic                  fl_vld [ENC_LATENCY+1];
  logic [ID_W-1:0]       fl_id  [ENC_LATENCY+1];
  logic                  fl_err [ENC_LATENCY+1];

  // Credit covers both words still in the encoder and words parked in the FIFO.
  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s <= ENC_LATENCY; s++) inflight_cnt = inflight_cnt + OCC_W'(fl_vld[s]);
  end

  assign occupancy  = OCC_W'(fifo_count) + inflight_cnt;
  assign has_credit = occupancy < OCC_W'(FIFO_DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign issue      = !rst && has_credit && grant_found;
  assign grant_data = req_data[int'(grant_idx)*CODEWORD_W +: CODEWORD_W];
  assign grant_mod  = req_mod[int'(grant_idx)*2 +: 2];

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        last_grant <= ID_W'(NUM_REQ - 1);
    else if (issue) last_grant <= grant_idx;
  end

  // Stage p0: issue register; idle cycles present the illegal mode so the encoder emits zeros.
  always_ff @(posedge clk) begin
    if (issue) begin
      enc_data_in <= grant_data;
      enc_mod     <= grant_mod;
    end else begin
      enc_data_in <= '0;
      enc_mod     <= MOD_ILLEGAL;
    end
  end

  // In-flight tracker: tail stage lines up with enc_data_out for the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= ENC_LATENCY; s++) fl_vld[s] <= 1'b0;
    end else begin
      fl_vld[0] <= issue;
      for (int s = 1; s <= ENC_LATENCY; s++) fl_vld[s] <= fl_vld[s-1];
    end
  end

  always_ff @(posedge clk) begin
    fl_id[0]  <= grant_idx;
    fl_err[0] <= is_illegal_mod(grant_mod);
    for (int s = 1; s <= ENC_LATENCY; s++) begin
      fl_id[s]  <= fl_id[s-1];
      fl_err[s] <= fl_err[s-1];
    end
  end

  // Response stage: tail capture into the FIFO, head presented directly.
  assign fifo_push  = fl_vld[ENC_LATENCY];
  assign fifo_wdata = {enc_data_out, fl_id[ENC_LATENCY], fl_err[ENC_LATENCY]};
  assign fifo_pop   = rsp_valid && rsp_ready;
  assign rsp_valid  = !fifo_empty;
  assign {rsp_data, rsp_id, rsp_err} = fifo_rdata;

  ecc_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_push && fifo_full));
  end

`ifdef ECC_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      stat_issue_cnt <= sat_inc(stat_issue_cnt, issue);
      stat_stall_cnt <= sat_inc(stat_stall_cnt, (|req_valid) && !has_credit);
    end
  end
`endif

endmodule

// File: doc/ecc_enc_sched.md
# ecc_enc_sched

Round-robin scheduler that shares one ECC encoder stage (8/16/32-bit codeword modes) among `NUM_REQ` requesters. It grants one request per cycle, drives the encoder input and mode, tracks in-flight words through the encoder's fixed latency, and returns each codeword with its requester ID through a credit-protected output FIFO. It sits between the per-channel ingress logic and the shared encoder pipeline.

## Interface
- `NUM_REQ`, 4: number of requester channels (2..8).
- `CODEWORD_W`, 32: encoder data width.
- `ENC_LATENCY`, 1: clock edges from encoder input presented to `enc_data_out` valid (1..4).
- `FIFO_DEPTH`, 4: output FIFO entries, a power of 2 that is at least 2.
- `ID_W`, $clog2(NUM_REQ): derived, not overridden.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `req_data` in NUM_REQ*CODEWORD_W: per-requester data. Requester i occupies slice [i*CODEWORD_W +: CODEWORD_W].
- `req_mod` in NUM_REQ*2: per-requester mode. Requester i occupies slice [i*2 +: 2].
- `enc_data_in` out CODEWORD_W: registered encoder data input.
- `enc_mod` out 2: registered encoder mode.
- `enc_data_out` in CODEWORD_W: encoder result.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_data` out CODEWORD_W: codeword.
- `rsp_id` out ID_W: originating requester.
- `rsp_err` out 1: request carried illegal mode 2'b11.

## Operation
- **Credit.** A new issue is allowed only when `fifo_count + inflight_count < FIFO_DEPTH`. Both counts are sampled at cycle start, and a pop in the same cycle does not grant extra credit.
- **Arbitration.** The search starts at `last_grant+1` and wraps modulo NUM_REQ. The first requester with `req_valid` gets `req_ready`. `req_ready` is combinational from `req_valid`, the credit check and the pointer. At most one bit is high, and all are low when there is no credit.
- **Pointer update.** On a handshake (`req_valid[i] & req_ready[i]`), `last_grant` becomes i. Otherwise it holds.
- **Issue register.**
  - On a handshake, `enc_data_in` and `enc_mod` take the granted slice on the next edge.
  - On a non-issue cycle, `enc_data_in` is 0 and `enc_mod` is 2'b11, which makes the encoder output all zeros.
- **In-flight tracking.** An `ENC_LATENCY+1`-deep shift register carries {valid, id, err} per issue. `err` = (mode == 2'b11). Illegal modes are still issued, and the zero codeword returns with `rsp_err=1`.
- **FIFO push.** When the tail stage of the shift register is valid, {`enc_data_out`, id, err} is pushed. Credit accounting guarantees the FIFO is never written when full. Overflow is an assertion failure.
- **FIFO pop.** Pop on `rsp_valid & rsp_ready`. A simultaneous push and pop leaves `fifo_count` unchanged. Push into an empty FIFO with no pop makes `rsp_valid` high on the next cycle; there is no bypass.
- **Response hold.** `rsp_data`, `rsp_id` and `rsp_err` are stable while `rsp_valid & !rsp_ready`.

## Timing
- **Reset values:**
  - `req_ready` = 0 for the reset cycle.
  - `enc_data_in` = 0, `enc_mod` = 2'b11.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `rsp_err` = 0.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - FIFO and shift register are empty.
- **Latency.** A handshake in cycle C gives `rsp_valid` in cycle C+ENC_LATENCY+2 at the earliest (default C+3).
- **Throughput.** One issue per cycle while `rsp_ready` stays high and credit is available.
- **Reset mid-operation.** In-flight entries and FIFO contents are discarded. No response appears after `rst` deasserts until new requests are accepted.
- **Back-pressure.** With `rsp_ready` low, at most FIFO_DEPTH requests are accepted before all `req_ready` bits go low.

## Configuration
- `ECC_SCHED_STATS_EN` defined:
  - Adds outputs `stat_issue_cnt[15:0]` (handshakes) and `stat_stall_cnt[15:0]` (cycles with any `req_valid` high but no credit).
  - Both are saturating at 16'hFFFF and cleared by `rst`.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Structure
- **Shared package `ecc_pkg`:**
  - Mode constants `MOD_8=2'b00`, `MOD_16=2'b01`, `MOD_32=2'b10`, `MOD_ILLEGAL=2'b11`.
  - `CODEWORD_W_DEF=32`.
  - Response struct typedef {data, id, err}.
- **Sub-module `ecc_rsp_fifo`:** synchronous FIFO parameterised by width and depth, exposing `count`, `full` and `empty`. Arbiter, credit logic and in-flight shift register stay in `ecc_enc_sched`.

## Test plan
1. **Reset, then single request.** `rst` high 2 cycles, then `req_valid[2]=1`, `req_data` slice = 32'h0000_000A, `req_mod`=2'b00 for one cycle. Expect `req_ready=4'b0100`, then `rsp_valid` 3 cycles later with `rsp_id=2`, `rsp_err=0`, and `rsp_data` equal to the reference-model 8-bit codeword.
2. **Round-robin fairness.** All four requesters continuously valid, `rsp_ready=1`. Expect grants in order 0,1,2,3,0,… with one grant per cycle, and `rsp_id` returning in the same order.
3. **Back-pressure.** `rsp_ready=0` with all requesters valid. Expect exactly 4 handshakes, then `req_ready=0`. Raise `rsp_ready` and expect 4 responses back to back, then grants resume.
4. **Illegal mode.** `req_mod`=2'b11 on requester 1. Expect a response with `rsp_err=1`, `rsp_data=0`, `rsp_id=1`.
5. **Reset mid-flight.** 3 requests in flight, then a 1-cycle `rst`. Expect no `rsp_valid` for 5 cycles with no requests, and the first grant afterwards goes to requester 0.
6. **Stats (`ECC_SCHED_STATS_EN`).** Run scenario 3. Expect `stat_issue_cnt` = 8 after draining, and `stat_stall_cnt` equal to the number of cycles `req_ready` was all-zero while any `req_valid` was high.
